// File: rtl/xdom_pulse_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// xdom_pulse_pkg : channel state encoding and default parameters   Rev 1.0
// ---------------------------------------------------------------------------
package xdom_pulse_pkg;

   localparam int DEF_CHANNELS    = 4;
   localparam int DEF_CNT_W       = 4;
   localparam int DEF_SYNC_STAGES = 2;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_REL  = 2'd2
   } chan_state_e;

endpackage
`default_nettype wire

// File: rtl/xdom_pq_chan.sv
`default_nettype none
// ---------------------------------------------------------------------------
// xdom_pq_chan : one pulse channel (edge detect, queue counter, 4-phase FSM,
// ack synchroniser, overflow flag; sticky flag with XDOM_PQ_ERR_STICKY_EN)   Rev 1.0
// ---------------------------------------------------------------------------
module xdom_pq_chan
   import xdom_pulse_pkg::*;
#(
   parameter int CNT_W       = DEF_CNT_W,
   parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             pulse_i,
   input  logic             ack_i,
`ifdef XDOM_PQ_ERR_STICKY_EN
   input  logic             err_clr_i,
`endif
   output logic             req_o,
   output logic             busy_o,
   output logic [CNT_W-1:0] pending_o,
   output logic             err_o
);

   localparam logic [CNT_W-1:0] C_ONE = CNT_W'(1);
   localparam logic [CNT_W-1:0] C_MAX = {CNT_W{1'b1}};

   chan_state_e            state_q, state_d;
   logic [CNT_W-1:0]       count_q, count_d;
   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic                   pulse_dly_q, pulse_dly_d;
   logic                   req_q, req_d;
   logic                   err_q, err_d;
   logic                   inc, dec, ovf, ack_s;

   always_comb begin
      pulse_dly_d = pulse_i;
      sync_d      = {sync_q[SYNC_STAGES-2:0], ack_i};
      ack_s       = sync_q[SYNC_STAGES-1];
      inc         = pulse_i & ~pulse_dly_q;
      state_d     = state_q;
      req_d       = 1'b0;
      dec         = 1'b0;
      count_d     = count_q;
      ovf         = 1'b0;

      // REL only returns to IDLE, so a new dequeue always sees one IDLE cycle first
      case (state_q)
         ST_IDLE: begin
            if (count_q != '0) begin
               state_d = ST_REQ;
               req_d   = 1'b1;
               dec     = 1'b1;
            end
         end
         ST_REQ: begin
            req_d = 1'b1;
            if (ack_s) begin
               state_d = ST_REL;
               req_d   = 1'b0;
            end
         end
         ST_REL: begin
            if (!ack_s) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase

      if (inc && !dec) begin
         if (count_q == C_MAX) ovf = 1'b1;
         else                  count_d = count_q + C_ONE;
      end else if (dec && !inc) begin
         count_d = count_q - C_ONE;
      end

`ifdef XDOM_PQ_ERR_STICKY_EN
      err_d = ovf | (err_q & ~err_clr_i);
`else
      err_d = ovf;
`endif
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         count_q     <= '0;
         sync_q      <= '0;
         pulse_dly_q <= 1'b0;
         req_q       <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         count_q     <= count_d;
         sync_q      <= sync_d;
         pulse_dly_q <= pulse_dly_d;
         req_q       <= req_d;
         err_q       <= err_d;
      end
   end

   assign req_o     = req_q;
   assign busy_o    = (state_q != ST_IDLE) | (count_q != '0) | inc;
   assign pending_o = count_q;
   assign err_o     = err_q;

endmodule
`default_nettype wire

// File: rtl/xdom_pulse_queue_tx.sv
`default_nettype none
// ---------------------------------------------------------------------------
// xdom_pulse_queue_tx : multi-channel queued pulse sender over 4-phase req/ack.
// Macro XDOM_PQ_ERR_STICKY_EN makes err_o sticky and adds err_clr_i.   Rev 1.0
// ---------------------------------------------------------------------------
module xdom_pulse_queue_tx
   import xdom_pulse_pkg::*;
#(
   parameter int CHANNELS    = DEF_CHANNELS,
   parameter int CNT_W       = DEF_CNT_W,
   parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
   input  logic                      odom_clk_i,
   input  logic                      grst_i,
   input  logic [CHANNELS-1:0]       pulse_i,
   output logic [CHANNELS-1:0]       req_o,
   input  logic [CHANNELS-1:0]       ack_i,
   output logic [CHANNELS-1:0]       busy_o,
   output logic [CHANNELS*CNT_W-1:0] pending_o,
`ifdef XDOM_PQ_ERR_STICKY_EN
   input  logic [CHANNELS-1:0]       err_clr_i,
`endif
   output logic [CHANNELS-1:0]       err_o
);

   for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_chan
      xdom_pq_chan #(
         .CNT_W       (CNT_W),
         .SYNC_STAGES (SYNC_STAGES)
      ) u_chan (
         .clk       (odom_clk_i),
         .rst       (grst_i),
         .pulse_i   (pulse_i[gi]),
         .ack_i     (ack_i[gi]),
`ifdef XDOM_PQ_ERR_STICKY_EN
         .err_clr_i (err_clr_i[gi]),
`endif
         .req_o     (req_o[gi]),
         .busy_o    (busy_o[gi]),
         .pending_o (pending_o[gi*CNT_W +: CNT_W]),
         .err_o     (err_o[gi])
      );
   end

endmodule
`default_nettype wire

// File: tb/tb_xdom_pulse_queue_tx.sv
`default_nettype none
// tb_xdom_pulse_queue_tx : directed and randomized scenarios checked against a
// queue/handshake reference model and a reactive far-side acknowledger.
module tb_xdom_pulse_queue_tx;

   localparam int CH   = 4;
   localparam int CW   = 4;
   localparam int SS   = 2;
   localparam int MAXQ = (1 << CW) - 1;
   localparam int VW   = CH * (3 + CW);

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic [CH-1:0]     pulse_i = '0;
   logic [CH-1:0]     ack_i = '0;
   logic [CH-1:0]     req_o, busy_o, err_o;
   logic [CH*CW-1:0]  pending_o;
`ifdef XDOM_PQ_ERR_STICKY_EN
   logic [CH-1:0]     err_clr_i = '0;
`endif

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   xdom_pulse_queue_tx #(.CHANNELS(CH), .CNT_W(CW), .SYNC_STAGES(SS)) dut (
      .odom_clk_i (clk),
      .grst_i     (rst),
      .pulse_i    (pulse_i),
      .req_o      (req_o),
      .ack_i      (ack_i),
      .busy_o     (busy_o),
      .pending_o  (pending_o),
`ifdef XDOM_PQ_ERR_STICKY_EN
      .err_clr_i  (err_clr_i),
`endif
      .err_o      (err_o)
   );

   // Reference model: queued pulses, link phase (0 free, 1 request out, 2 awaiting release),
   // and the ack history as seen after the synchroniser delay.
   int m_cnt  [CH];
   int m_ph   [CH];
   int m_xfer [CH];
   bit m_pd   [CH];
   bit m_err  [CH];
   bit m_ackh [CH][SS];

   always @(posedge clk) begin
      int inc_v, dec_v, want_v;
      bit ovf_v, acks_v;
      for (int i = 0; i < CH; i++) begin
         if (rst) begin
            m_cnt[i] = 0; m_ph[i] = 0; m_pd[i] = 0; m_err[i] = 0;
            for (int s = 0; s < SS; s++) m_ackh[i][s] = 0;
         end else begin
            acks_v = m_ackh[i][SS-1];
            inc_v  = (pulse_i[i] && !m_pd[i]) ? 1 : 0;
            dec_v  = (m_ph[i] == 0 && m_cnt[i] > 0) ? 1 : 0;
            want_v = m_cnt[i] + inc_v - dec_v;
            ovf_v  = (want_v > MAXQ);
            m_cnt[i]  = ovf_v ? MAXQ : want_v;
            m_xfer[i] += dec_v;
            if (dec_v == 1)                m_ph[i] = 1;
            else if (m_ph[i] == 1 && acks_v)  m_ph[i] = 2;
            else if (m_ph[i] == 2 && !acks_v) m_ph[i] = 0;
`ifdef XDOM_PQ_ERR_STICKY_EN
            m_err[i] = ovf_v || (m_err[i] && !err_clr_i[i]);
`else
            m_err[i] = ovf_v;
`endif
            for (int s = SS - 1; s > 0; s--) m_ackh[i][s] = m_ackh[i][s-1];
            m_ackh[i][0] = ack_i[i];
            m_pd[i] = pulse_i[i];
         end
      end
   end

   function automatic logic [VW-1:0] exp_vec();
      logic [CH-1:0]    r, b, e;
      logic [CH*CW-1:0] p;
      for (int i = 0; i < CH; i++) begin
         r[i] = (m_ph[i] == 1);
         b[i] = (m_ph[i] != 0) || (m_cnt[i] != 0) || (pulse_i[i] && !m_pd[i]);
         e[i] = m_err[i];
         p[i*CW +: CW] = CW'(m_cnt[i]);
      end
      return {r, b, e, p};
   endfunction

   function automatic bit model_idle(int ch);
      return (m_ph[ch] == 0 && m_cnt[ch] == 0);
   endfunction

   // Far side: mirrors req onto ack after fs_dly cycles of disagreement
   bit fs_hold [CH];
   int fs_dly  [CH];
   int fs_cnt  [CH];

   always @(negedge clk) begin
      for (int i = 0; i < CH; i++) begin
         if (fs_hold[i]) begin
            ack_i[i] = 1'b0; fs_cnt[i] = 0;
         end else if (ack_i[i] !== req_o[i]) begin
            fs_cnt[i]++;
            if (fs_cnt[i] >= fs_dly[i]) begin
               ack_i[i] = req_o[i]; fs_cnt[i] = 0;
            end
         end else begin
            fs_cnt[i] = 0;
         end
      end
   end

   int            dut_rises [CH];
   logic [CH-1:0] req_prev = '0;

   always @(negedge clk) begin
      for (int i = 0; i < CH; i++)
         if (req_o[i] === 1'b1 && req_prev[i] !== 1'b1) dut_rises[i]++;
      req_prev = req_o;
   end

   task automatic test_reset();
      rst = 1'b1;
      pulse_i = '0;
      repeat (3) @(negedge clk);
      checks++; if (req_o !== '0)     begin errors++; $display("FAIL reset_req: got %h expected 0", req_o); end
      checks++; if (busy_o !== '0)    begin errors++; $display("FAIL reset_busy: got %h expected 0", busy_o); end
      checks++; if (pending_o !== '0) begin errors++; $display("FAIL reset_pending: got %h expected 0", pending_o); end
      checks++; if (err_o !== '0)     begin errors++; $display("FAIL reset_err: got %h expected 0", err_o); end
      rst = 1'b0;
      @(negedge clk);
      checks++;
      if ({req_o, busy_o, err_o, pending_o} !== exp_vec()) begin
         errors++; $display("FAIL reset_release: got %h expected %h", {req_o, busy_o, err_o, pending_o}, exp_vec());
      end
   endtask

   task automatic test_single();
      int r0, n;
      r0 = dut_rises[0];
      pulse_i[0] = 1'b1;
      #1;
      checks++; if (busy_o[0] !== 1'b1) begin errors++; $display("FAIL single_busy_on_edge: got %b expected 1", busy_o[0]); end
      @(negedge clk);
      checks++; if (pending_o[CW-1:0] !== CW'(1)) begin errors++; $display("FAIL single_count: got %0d expected 1", pending_o[CW-1:0]); end
      checks++; if (req_o[0] !== 1'b0) begin errors++; $display("FAIL single_req_early: got %b expected 0", req_o[0]); end
      pulse_i[0] = 1'b0;
      @(negedge clk);
      checks++; if (req_o[0] !== 1'b1) begin errors++; $display("FAIL single_req_latency: got %b expected 1", req_o[0]); end
      n = 0;
      while (!model_idle(0) && n < 200) begin
         @(negedge clk); n++;
         checks++;
         if ({req_o, busy_o, err_o, pending_o} !== exp_vec()) begin
            errors++; $display("FAIL single_cycle: got %h expected %h", {req_o, busy_o, err_o, pending_o}, exp_vec());
         end
      end
      checks++; if (n >= 200) begin errors++; $display("FAIL single_timeout: got %0d cycles expected <200", n); end
      checks++; if (busy_o[0] !== 1'b0) begin errors++; $display("FAIL single_busy_end: got %b expected 0", busy_o[0]); end
      checks++; if (err_o[0] !== 1'b0) begin errors++; $display("FAIL single_err: got %b expected 0", err_o[0]); end
      checks++; if (dut_rises[0] - r0 !== 1) begin errors++; $display("FAIL single_transfers: got %0d expected 1", dut_rises[0] - r0); end
   endtask

   task automatic test_back_to_back();
      int r0, n, peak;
      r0 = dut_rises[1];
      peak = 0;
      for (int k = 0; k < 10; k++) begin
         pulse_i[1] = (k % 2 == 0);
         @(negedge clk);
         checks++;
         if ({req_o, busy_o, err_o, pending_o} !== exp_vec()) begin
            errors++; $display("FAIL b2b_cycle: got %h expected %h", {req_o, busy_o, err_o, pending_o}, exp_vec());
         end
         if (int'(pending_o[CW +: CW]) > peak) peak = int'(pending_o[CW +: CW]);
      end
      pulse_i[1] = 1'b0;
      n = 0;
      while (!model_idle(1) && n < 400) begin
         @(negedge clk); n++;
         checks++;
         if ({req_o, busy_o, err_o, pending_o} !== exp_vec()) begin
            errors++; $display("FAIL b2b_drain: got %h expected %h", {req_o, busy_o, err_o, pending_o}, exp_vec());
         end
         if (int'(pending_o[CW +: CW]) > peak) peak = int'(pending_o[CW +: CW]);
      end
      checks++; if (n >= 400) begin errors++; $display("FAIL b2b_timeout: got %0d cycles expected <400", n); end
      checks++; if (peak !== 4) begin errors++; $display("FAIL b2b_peak: got %0d expected 4", peak); end
      checks++; if (dut_rises[1] - r0 !== 5) begin errors++; $display("FAIL b2b_transfers: got %0d expected 5", dut_rises[1] - r0); end
      checks++; if (pending_o[CW +: CW] !== '0) begin errors++; $display("FAIL b2b_pending_end: got %0d expected 0", pending_o[CW +: CW]); end
   endtask

   task automatic test_overflow();
      int r0, n, err_cycles;
      r0 = dut_rises[2];
      err_cycles = 0;
      fs_hold[2] = 1'b1;
      for (int k = 0; k < 2 * (MAXQ + 2) + 6; k++) begin
         pulse_i[2] = (k < 2 * (MAXQ + 2)) && (k % 2 == 0);
         @(negedge clk);
         checks++;
         if ({req_o, busy_o, err_o, pending_o} !== exp_vec()) begin
            errors++; $display("FAIL ovf_cycle: got %h expected %h", {req_o, busy_o, err_o, pending_o}, exp_vec());
         end
         if (err_o[2] === 1'b1) err_cycles++;
      end
      checks++; if (pending_o[2*CW +: CW] !== CW'(MAXQ)) begin errors++; $display("FAIL ovf_saturate: got %0d expected %0d", pending_o[2*CW +: CW], MAXQ); end
`ifdef XDOM_PQ_ERR_STICKY_EN
      checks++; if (err_o[2] !== 1'b1) begin errors++; $display("FAIL ovf_sticky_held: got %b expected 1", err_o[2]); end
      pulse_i[2] = 1'b1;
      err_clr_i[2] = 1'b1;
      @(negedge clk);
      checks++; if (err_o[2] !== 1'b1) begin errors++; $display("FAIL sticky_set_wins: got %b expected 1", err_o[2]); end
      pulse_i[2] = 1'b0;
      @(negedge clk);
      checks++; if (err_o[2] !== 1'b0) begin errors++; $display("FAIL sticky_clear: got %b expected 0", err_o[2]); end
      err_clr_i[2] = 1'b0;
`else
      checks++; if (err_cycles !== 1) begin errors++; $display("FAIL ovf_err_pulses: got %0d expected 1", err_cycles); end
`endif
      fs_hold[2] = 1'b0;
      n = 0;
      while (!model_idle(2) && n < 1000) begin
         @(negedge clk); n++;
         checks++;
         if ({req_o, busy_o, err_o, pending_o} !== exp_vec()) begin
            errors++; $display("FAIL ovf_drain: got %h expected %h", {req_o, busy_o, err_o, pending_o}, exp_vec());
         end
      end
      checks++; if (n >= 1000) begin errors++; $display("FAIL ovf_timeout: got %0d cycles expected <1000", n); end
      checks++; if (dut_rises[2] - r0 !== MAXQ + 1) begin errors++; $display("FAIL ovf_transfers: got %0d expected %0d", dut_rises[2] - r0, MAXQ + 1); end
   endtask

   task automatic test_dequeue_collision();
      int r0, n;
      r0 = dut_rises[0];
      for (int k = 0; k < 4; k++) begin
         pulse_i[0] = (k % 2 == 0);
         @(negedge clk);
      end
      pulse_i[0] = 1'b0;
      n = 0;
      while (!(m_ph[0] == 0 && m_cnt[0] == 1) && n < 200) begin
         @(negedge clk); n++;
         checks++;
         if ({req_o, busy_o, err_o, pending_o} !== exp_vec()) begin
            errors++; $display("FAIL coll_wait: got %h expected %h", {req_o, busy_o, err_o, pending_o}, exp_vec());
         end
      end
      checks++; if (n >= 200) begin errors++; $display("FAIL coll_timeout: got %0d cycles expected <200", n); end
      pulse_i[0] = 1'b1;
      @(negedge clk);
      checks++; if (pending_o[CW-1:0] !== CW'(1)) begin errors++; $display("FAIL coll_count: got %0d expected 1", pending_o[CW-1:0]); end
      checks++; if (req_o[0] !== 1'b1) begin errors++; $display("FAIL coll_req: got %b expected 1", req_o[0]); end
      pulse_i[0] = 1'b0;
      n = 0;
      while (!model_idle(0) && n < 300) begin
         @(negedge clk); n++;
         checks++;
         if ({req_o, busy_o, err_o, pending_o} !== exp_vec()) begin
            errors++; $display("FAIL coll_drain: got %h expected %h", {req_o, busy_o, err_o, pending_o}, exp_vec());
         end
      end
      checks++; if (dut_rises[0] - r0 !== 3) begin errors++; $display("FAIL coll_transfers: got %0d expected 3", dut_rises[0] - r0); end
   endtask

   task automatic test_reset_mid();
      int n;
      bit req_seen;
      for (int k = 0; k < 6; k++) begin
         pulse_i[3] = (k % 2 == 0);
         @(negedge clk);
      end
      pulse_i[3] = 1'b0;
      n = 0;
      while (!(m_ph[3] == 1 && m_cnt[3] == 2) && n < 50) begin
         @(negedge clk); n++;
      end
      checks++; if (n >= 50) begin errors++; $display("FAIL rmid_setup: got %0d cycles expected <50", n); end
      checks++; if (req_o[3] !== 1'b1 || pending_o[3*CW +: CW] !== CW'(2)) begin
         errors++; $display("FAIL rmid_pre: got req %b pending %0d expected req 1 pending 2", req_o[3], pending_o[3*CW +: CW]);
      end
      rst = 1'b1;
      @(negedge clk);
      checks++; if ({req_o, busy_o, err_o, pending_o} !== '0) begin
         errors++; $display("FAIL rmid_clear: got %h expected 0", {req_o, busy_o, err_o, pending_o});
      end
      rst = 1'b0;
      req_seen = 1'b0;
      repeat (20) begin
         @(negedge clk);
         if (req_o[3] === 1'b1) req_seen = 1'b1;
      end
      checks++; if (req_seen !== 1'b0) begin errors++; $display("FAIL rmid_no_req: got %b expected 0", req_seen); end
      checks++; if ({req_o, busy_o, err_o, pending_o} !== exp_vec()) begin
         errors++; $display("FAIL rmid_after: got %h expected %h", {req_o, busy_o, err_o, pending_o}, exp_vec());
      end
   endtask

   task automatic test_random();
      int r0 [CH];
      int x0 [CH];
      int n;
      for (int i = 0; i < CH; i++) begin
         fs_dly[i] = int'($urandom_range(1, 4));
         r0[i] = dut_rises[i];
         x0[i] = m_xfer[i];
      end
      for (int k = 0; k < 400; k++) begin
         pulse_i = CH'($urandom);
         @(negedge clk);
         checks++;
         if ({req_o, busy_o, err_o, pending_o} !== exp_vec()) begin
            errors++; $display("FAIL rand_cycle %0d: got %h expected %h", k, {req_o, busy_o, err_o, pending_o}, exp_vec());
         end
      end
      pulse_i = '0;
      n = 0;
      while (!(model_idle(0) && model_idle(1) && model_idle(2) && model_idle(3)) && n < 1500) begin
         @(negedge clk); n++;
         checks++;
         if ({req_o, busy_o, err_o, pending_o} !== exp_vec()) begin
            errors++; $display("FAIL rand_drain: got %h expected %h", {req_o, busy_o, err_o, pending_o}, exp_vec());
         end
      end
      checks++; if (n >= 1500) begin errors++; $display("FAIL rand_timeout: got %0d cycles expected <1500", n); end
      for (int i = 0; i < CH; i++) begin
         checks++;
         if (dut_rises[i] - r0[i] !== m_xfer[i] - x0[i]) begin
            errors++; $display("FAIL rand_transfers ch%0d: got %0d expected %0d", i, dut_rises[i] - r0[i], m_xfer[i] - x0[i]);
         end
      end
   endtask

   initial begin
      for (int i = 0; i < CH; i++) begin
         fs_dly[i] = 3; fs_hold[i] = 1'b0;
      end
      test_reset();
      test_single();
      test_back_to_back();
      test_overflow();
      test_dequeue_collision();
      test_reset_mid();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
`default_nettype wire
